// File: rtl/rv32i_types.sv
// RVFI monitor record that travels alongside each decoded instruction.
package rv32i_types;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] inst;
        logic        trap;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_word;

endpackage

// File: rtl/tomasula_types.sv
// Issue-queue control word produced by the fetch/decode front end.
package tomasula_types;

    typedef enum logic [3:0] {
        s_op_invalid,
        s_op_imm,
        s_op_reg,
        s_op_load,
        s_op_store,
        s_op_br,
        s_op_lui,
        s_op_auipc,
        s_op_jal,
        s_op_jalr
    } op_t;

    typedef struct packed {
        op_t         opcode;
        logic [31:0] og_instr;
        logic [31:0] og_pc;
        logic [31:0] pc;
        logic [2:0]  funct3;
        logic        funct7;
        logic [4:0]  src1_reg;
        logic        src1_valid;
        logic [4:0]  src2_reg;
        logic        src2_valid;
        logic [31:0] src2_data;
    } ctl_word;

endpackage

// File: rtl/ir_fetch_decode.sv
// Single-instruction fetch/decode front end: fetches from imem, decodes to a control word
// plus RVFI record, and offers it to the issue queue; owns the fetch PC (JAL and flush steering).
module ir_fetch_decode
    import tomasula_types::*;
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_ip,
    input  logic [31:0] redirect_pc,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        ld_iq,
    output ctl_word     control_word,
    output rvfi_word    rvfi,
    input  logic        issue_q_full_n,
    input  logic        ack_i
);

    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;

    typedef enum logic [1:0] {StFetch, StIssue, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    ctl_word     cw_q, cw_d, dec_cw;
    rvfi_word    rvfi_q, rvfi_d, dec_rvfi;
    logic        dec_legal;

    // The transfer is qualified by ack_i alone; queue-full is advisory here.
    logic unused_q_full;
    assign unused_q_full = issue_q_full_n;

    logic [6:0]  opc;
    logic [4:0]  rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opc   = imem_rdata[6:0];
    assign rs1   = imem_rdata[19:15];
    assign rs2   = imem_rdata[24:20];
    assign imm_i = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
    assign imm_s = {{20{imem_rdata[31]}}, imem_rdata[31:25], imem_rdata[11:7]};
    assign imm_b = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7], imem_rdata[30:25],
                    imem_rdata[11:8], 1'b0};
    assign imm_j = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12], imem_rdata[20],
                    imem_rdata[30:21], 1'b0};
    assign imm_u = {imem_rdata[31:12], 12'b0};

    always_comb begin
        dec_legal       = 1'b1;
        dec_cw          = '0;
        dec_cw.og_instr = imem_rdata;
        dec_cw.og_pc    = pc_q;
        dec_cw.funct3   = imem_rdata[14:12];
        dec_cw.funct7   = imem_rdata[30];
        dec_cw.pc       = pc_q + 32'd4;
        case (opc)
            OpImm: begin
                dec_cw.opcode     = s_op_imm;
                dec_cw.src1_reg   = rs1;
                dec_cw.src2_valid = 1'b1;
                dec_cw.src2_data  = imm_i;
            end
            OpReg: begin
                dec_cw.opcode   = s_op_reg;
                dec_cw.src1_reg = rs1;
                dec_cw.src2_reg = rs2;
            end
            OpLoad: begin
                dec_cw.opcode     = s_op_load;
                dec_cw.src1_reg   = rs1;
                dec_cw.src2_valid = 1'b1;
                dec_cw.src2_data  = imm_i;
            end
            OpStore: begin
                dec_cw.opcode    = s_op_store;
                dec_cw.src1_reg  = rs1;
                dec_cw.src2_reg  = rs2;
                dec_cw.src2_data = imm_s;
            end
            OpBr: begin
                dec_cw.opcode    = s_op_br;
                dec_cw.src1_reg  = rs1;
                dec_cw.src2_reg  = rs2;
                dec_cw.src2_data = imm_b;
            end
            OpLui, OpAuipc: begin
                dec_cw.opcode     = (opc == OpLui) ? s_op_lui : s_op_auipc;
                dec_cw.src1_valid = 1'b1;
                dec_cw.src2_valid = 1'b1;
                dec_cw.src2_data  = imm_u;
            end
            OpJal: begin
                dec_cw.opcode     = s_op_jal;
                dec_cw.src1_valid = 1'b1;
                dec_cw.src2_valid = 1'b1;
                dec_cw.src2_data  = imm_j;
                dec_cw.pc         = pc_q + imm_j;
            end
            OpJalr: begin
                // Predicted fall-through; the back end flushes on a mispredict.
                dec_cw.opcode     = s_op_jalr;
                dec_cw.src1_reg   = rs1;
                dec_cw.src2_valid = 1'b1;
                dec_cw.src2_data  = imm_i;
            end
            default: dec_legal = 1'b0;
        endcase

        dec_rvfi          = '0;
        dec_rvfi.valid    = 1'b1;
        dec_rvfi.inst     = imem_rdata;
        dec_rvfi.rs1_addr = dec_cw.src1_reg;
        dec_rvfi.rs2_addr = dec_cw.src2_reg;
        dec_rvfi.pc_rdata = pc_q;
        dec_rvfi.pc_wdata = dec_cw.pc;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        cw_d         = cw_q;
        rvfi_d       = rvfi_q;
        imem_read    = 1'b0;
        imem_address = {pc_q[31:2], 2'b00};
        ld_iq        = 1'b0;
        case (state_q)
            StFetch: begin
                imem_read = 1'b1;
                if (flush_ip) begin
                    pc_d = redirect_pc;
                    // The cache cannot abort, so wait out the request at its old address.
                    if (!imem_resp) begin
                        state_d      = StDrain;
                        drain_addr_d = imem_address;
                    end
                end else if (imem_resp) begin
                    if (dec_legal) begin
                        cw_d    = dec_cw;
                        rvfi_d  = dec_rvfi;
                        state_d = StIssue;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            StIssue: begin
                ld_iq = ~flush_ip;
                if (flush_ip) begin
                    pc_d    = redirect_pc;
                    state_d = StFetch;
                end else if (ack_i) begin
                    pc_d    = cw_q.pc;
                    state_d = StFetch;
                end
            end
            StDrain: begin
                imem_read    = 1'b1;
                imem_address = drain_addr_q;
                if (flush_ip) begin
                    pc_d = redirect_pc;
                end
                if (imem_resp) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            cw_q         <= '0;
            rvfi_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            cw_q         <= cw_d;
            rvfi_q       <= rvfi_d;
        end
    end

    assign control_word = cw_q;
    assign rvfi         = rvfi_q;

endmodule

// File: tb/tb_ir_fetch_decode.sv
// Scoreboard bench for ir_fetch_decode: a reference decoder predicts each issued word,
// a monitor compares it at every ld_iq/ack_i transfer.
module tb_ir_fetch_decode;
    import tomasula_types::*;
    import rv32i_types::*;

    localparam logic [31:0] ResetPc = 32'h0000_0060;
    localparam logic [6:0] LegalOps [9] = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63,
                                            7'h37, 7'h17, 7'h6f, 7'h67};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_ip = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata = '0;
    logic        imem_resp = 1'b0;
    logic        ld_iq;
    ctl_word     control_word;
    rvfi_word    rvfi;
    logic        issue_q_full_n = 1'b1;
    logic        ack_i = 1'b0;

    ctl_word     exp_cw_q[$];
    rvfi_word    exp_rv_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] old_pc;

    ir_fetch_decode #(.RESET_PC(ResetPc)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_ip       (flush_ip),
        .redirect_pc    (redirect_pc),
        .imem_read      (imem_read),
        .imem_address   (imem_address),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .ld_iq          (ld_iq),
        .control_word   (control_word),
        .rvfi           (rvfi),
        .issue_q_full_n (issue_q_full_n),
        .ack_i          (ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cw(input string name, input ctl_word act, input ctl_word exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_rv(input string name, input rvfi_word act, input rvfi_word exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [31:0] ins);
        for (int i = 0; i < 9; i++) if (ins[6:0] == LegalOps[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Immediates computed as signed integers: the sign bit contributes -2^k.
    function automatic ctl_word ref_cw(input logic [31:0] ins, input logic [31:0] pc);
        ctl_word     w;
        logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
        imm_i = ins[30:20] - (ins[31] ? 32'd2048 : 32'd0);
        imm_s = ins[30:25] * 32'd32 + ins[11:7] - (ins[31] ? 32'd2048 : 32'd0);
        imm_b = ins[30:25] * 32'd32 + ins[11:8] * 32'd2 + ins[7] * 32'd2048
                - (ins[31] ? 32'd4096 : 32'd0);
        imm_j = ins[30:21] * 32'd2 + ins[20] * 32'd2048 + ins[19:12] * 32'd4096
                - (ins[31] ? 32'd1048576 : 32'd0);
        imm_u = ins[31:12] * 32'd4096;
        w          = '0;
        w.og_instr = ins;
        w.og_pc    = pc;
        w.funct3   = ins[14:12];
        w.funct7   = ins[30];
        w.pc       = pc + 32'd4;
        case (ins[6:0])
            7'h13: begin w.opcode = s_op_imm;   w.src1_reg = ins[19:15];
                         w.src2_valid = 1'b1; w.src2_data = imm_i; end
            7'h33: begin w.opcode = s_op_reg;   w.src1_reg = ins[19:15];
                         w.src2_reg = ins[24:20]; end
            7'h03: begin w.opcode = s_op_load;  w.src1_reg = ins[19:15];
                         w.src2_valid = 1'b1; w.src2_data = imm_i; end
            7'h23: begin w.opcode = s_op_store; w.src1_reg = ins[19:15];
                         w.src2_reg = ins[24:20]; w.src2_data = imm_s; end
            7'h63: begin w.opcode = s_op_br;    w.src1_reg = ins[19:15];
                         w.src2_reg = ins[24:20]; w.src2_data = imm_b; end
            7'h37, 7'h17: begin
                w.opcode = (ins[6:0] == 7'h37) ? s_op_lui : s_op_auipc;
                w.src1_valid = 1'b1; w.src2_valid = 1'b1; w.src2_data = imm_u;
            end
            7'h6f: begin w.opcode = s_op_jal; w.src1_valid = 1'b1; w.src2_valid = 1'b1;
                         w.src2_data = imm_j; w.pc = pc + imm_j; end
            7'h67: begin w.opcode = s_op_jalr; w.src1_reg = ins[19:15];
                         w.src2_valid = 1'b1; w.src2_data = imm_i; end
            default: w.opcode = s_op_invalid;
        endcase
        return w;
    endfunction

    function automatic rvfi_word ref_rv(input logic [31:0] ins, input logic [31:0] pc);
        rvfi_word r;
        ctl_word  w;
        bit       uses_rs1, uses_rs2;
        w        = ref_cw(ins, pc);
        uses_rs1 = ins[6:0] inside {7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h67};
        uses_rs2 = ins[6:0] inside {7'h33, 7'h23, 7'h63};
        r          = '0;
        r.valid    = 1'b1;
        r.inst     = ins;
        r.rs1_addr = uses_rs1 ? ins[19:15] : 5'd0;
        r.rs2_addr = uses_rs2 ? ins[24:20] : 5'd0;
        r.pc_rdata = pc;
        r.pc_wdata = w.pc;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int          k;
        ins = $urandom;
        k   = int'($urandom_range(0, 10));
        if (k < 9) ins[6:0] = LegalOps[k];
        else       ins[6:0] = (k == 9) ? 7'h7f : 7'h0b;
        if (ins[6:0] == 7'h6f) ins[21] = 1'b0;  // keep JAL targets word aligned
        return ins;
    endfunction

    // Monitor: pops the scoreboard on every accepted transfer.
    always @(negedge clk) begin
        #2;
        if (!rst && ld_iq && ack_i) begin
            if (exp_cw_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_transfer: got word %h, expected no transfer",
                         control_word);
            end else begin
                chk_cw("sb_ctl", control_word, exp_cw_q.pop_front());
                chk_rv("sb_rvfi", rvfi, exp_rv_q.pop_front());
            end
        end
    end

    // Called at a negedge with the DUT in FETCH at exp_pc; returns at a negedge in FETCH.
    // mode 0: normal ack, 1: flush together with ack, 2: async reset while in ISSUE.
    task automatic serve(input logic [31:0] ins, input int lat, input int stall,
                         input int mode, input logic [31:0] rpc);
        ctl_word  e;
        rvfi_word er;
        chk("fetch_read", 32'(imem_read), 32'd1);
        chk("fetch_addr", imem_address, exp_pc & 32'hFFFF_FFFC);
        for (int i = 0; i < lat; i++) begin
            ack_i          = 1'($urandom_range(0, 1));
            issue_q_full_n = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("read_held", 32'(imem_read), 32'd1);
            chk("addr_held", imem_address, exp_pc & 32'hFFFF_FFFC);
        end
        ack_i      = 1'b0;
        imem_resp  = 1'b1;
        imem_rdata = ins;
        @(negedge clk);
        imem_resp  = 1'b0;
        imem_rdata = $urandom;
        if (!ref_legal(ins)) begin
            exp_pc = exp_pc + 32'd4;
            chk("illegal_no_ld", 32'(ld_iq), 32'd0);
            chk("illegal_next_addr", imem_address, exp_pc);
            return;
        end
        e  = ref_cw(ins, exp_pc);
        er = ref_rv(ins, exp_pc);
        chk("issue_ld", 32'(ld_iq), 32'd1);
        chk("issue_no_read", 32'(imem_read), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk_cw("stall_ctl", control_word, e);
            chk_rv("stall_rvfi", rvfi, er);
            chk("stall_ld", 32'(ld_iq), 32'd1);
            chk("stall_no_read", 32'(imem_read), 32'd0);
        end
        if (mode == 1) begin
            flush_ip    = 1'b1;
            redirect_pc = rpc;
            ack_i       = 1'b1;
            #1;
            chk("flush_ack_no_ld", 32'(ld_iq), 32'd0);
            @(negedge clk);
            flush_ip = 1'b0;
            ack_i    = 1'b0;
            exp_pc   = rpc;
        end else if (mode == 2) begin
            rst = 1'b1;
            #1;
            chk("async_rst_ld", 32'(ld_iq), 32'd0);
            chk_cw("async_rst_ctl", control_word, ctl_word'('0));
            chk_rv("async_rst_rvfi", rvfi, rvfi_word'('0));
            @(negedge clk);
            rst    = 1'b0;
            exp_pc = ResetPc;
        end else begin
            exp_cw_q.push_back(e);
            exp_rv_q.push_back(er);
            ack_i = 1'b1;
            @(negedge clk);
            ack_i  = 1'b0;
            exp_pc = e.pc;
        end
        chk("next_fetch_read", 32'(imem_read), 32'd1);
        chk("next_fetch_addr", imem_address, exp_pc & 32'hFFFF_FFFC);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ld_iq", 32'(ld_iq), 32'd0);
        chk_cw("rst_ctl", control_word, ctl_word'('0));
        chk_rv("rst_rvfi", rvfi, rvfi_word'('0));
        rst = 1'b0;
        #1;
        chk("rst_read", 32'(imem_read), 32'd1);
        chk("rst_addr", imem_address, ResetPc);
        @(negedge clk);
        exp_pc = ResetPc;

        serve(32'h0050_0093, 1, 0, 0, '0);   // addi x1,x0,5 at 0x60
        serve(32'h0050_0093, 1, 4, 0, '0);   // four-cycle queue stall
        serve(32'h0000_007f, 1, 0, 0, '0);   // illegal word
        for (int i = 0; i < 5; i++) serve(32'h0010_0113, 0, 0, 0, '0);
        serve(32'hff9f_f06f, 1, 0, 0, '0);   // jal x0,-8 at 0x80

        // Flush two cycles before the response: drain at the old address.
        old_pc      = exp_pc;
        flush_ip    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        flush_ip = 1'b0;
        chk("drain_read", 32'(imem_read), 32'd1);
        chk("drain_addr", imem_address, old_pc);
        @(negedge clk);
        chk("drain_addr2", imem_address, old_pc);
        imem_resp  = 1'b1;
        imem_rdata = 32'h0050_0093;
        @(negedge clk);
        imem_resp = 1'b0;
        chk("drain_no_ld", 32'(ld_iq), 32'd0);
        exp_pc = 32'h0000_0200;
        chk("drain_next_fetch", imem_address, exp_pc);

        // Second flush while draining overwrites the target.
        flush_ip    = 1'b1;
        redirect_pc = 32'h0000_0240;
        @(negedge clk);
        redirect_pc = 32'h0000_0280;
        imem_resp   = 1'b1;
        @(negedge clk);
        flush_ip  = 1'b0;
        imem_resp = 1'b0;
        chk("drain_ovr_no_ld", 32'(ld_iq), 32'd0);
        exp_pc = 32'h0000_0280;
        chk("drain_ovr_addr", imem_address, exp_pc);

        // Flush coincident with the response in FETCH.
        flush_ip    = 1'b1;
        redirect_pc = 32'h0000_02c0;
        imem_resp   = 1'b1;
        imem_rdata  = 32'h0050_0093;
        @(negedge clk);
        flush_ip  = 1'b0;
        imem_resp = 1'b0;
        chk("fetch_flush_no_ld", 32'(ld_iq), 32'd0);
        exp_pc = 32'h0000_02c0;
        chk("fetch_flush_addr", imem_address, exp_pc);

        serve(32'h0050_0093, 1, 2, 1, 32'h0000_0300);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0)
                serve(rand_instr(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1,
                      $urandom & 32'hFFFF_FFFC);
            else
                serve(rand_instr(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0,
                      '0);
        end

        serve(32'h0050_0093, 1, 1, 2, '0);
        serve(32'h0050_0093, 0, 0, 0, '0);

        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_cw_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ir_fetch_decode.md
# ir_fetch_decode

Front-end producer for the issue queue. It fetches one instruction at a time from the instruction memory port and decodes it into a `tomasula_types::ctl_word` plus a matching `rv32i_types::rvfi_word`. It offers the pair to the issue queue over the IR-side `ld_iq`/ack handshake. It owns the architectural fetch PC and steers it on JAL and on back-end flushes.

## Interface
- `RESET_PC`, default 32'h0000_0060: fetch address after reset.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush_ip`  in  1  back-end redirect; `redirect_pc` is valid in the same cycle.
- `redirect_pc`  in  32  new fetch PC on flush.
- `imem_read`  out  1  instruction read request, held until `imem_resp`.
- `imem_address`  out  32  word address; equals the current fetch PC, low 2 bits 0.
- `imem_rdata`  in  32  instruction, valid with `imem_resp`.
- `imem_resp`  in  1  one-cycle read completion.
- `ld_iq`  out  1  `control_word`/`rvfi` valid toward the issue queue.
- `control_word`  out  ctl_word  decoded instruction.
- `rvfi`  out  rvfi_word  monitor record for the same instruction.
- `issue_q_full_n`  in  1  queue has space (informational; the transfer is qualified by `ack_i`).
- `ack_i`  in  1  the queue accepted the word this cycle.

## Operation
- States: FETCH, ISSUE, DRAIN. The reset state is FETCH, with `pc = RESET_PC`.
- FETCH:
  - `imem_read = 1`, `imem_address = pc`.
  - On `imem_resp`: decode `imem_rdata`.
  - Legal opcode: register the decoded word and go to ISSUE.
  - Illegal opcode: drop the word, set `pc <= pc+4`, stay in FETCH.
- ISSUE:
  - `ld_iq = ~flush_ip`; `imem_read = 0`.
  - A transfer happens on `ld_iq & ack_i`. Then `pc <= control_word.pc` and the state goes to FETCH.
  - With no `ack_i`, the word and `rvfi` stay stable.
- DRAIN:
  - Keeps `imem_read` high at the address issued before the flush. The cache cannot abort a request.
  - On `imem_resp`: discard the data and go to FETCH.
- Flush handling (`flush_ip`):
  - Always `pc <= redirect_pc`.
  - FETCH without `imem_resp`: go to DRAIN, with `imem_address` held at the old pc through DRAIN.
  - FETCH with `imem_resp` in the same cycle: discard the response and stay in FETCH.
  - ISSUE: drop the held word and go to FETCH; `ld_iq` is 0 that cycle.
  - DRAIN: overwrite the pending target.
- Decode, common fields:
  - `og_instr = instr`, `og_pc = pc`, `funct3 = instr[14:12]`, `funct7 = instr[30]`.
  - rd travels in `og_instr[11:7]`.
  - `pc` = predicted next PC: `og_pc + 4`, except for JAL.
- Decode, per opcode:
  - op-imm → `s_op_imm`: `src1_reg` = rs1, `src1_valid` = 0, `src2_valid` = 1, `src2_data` = sign-extended I-imm.
  - op → `s_op_reg`: `src2_reg` = rs2, `src2_valid` = 0.
  - load → `s_op_load`: `src2_valid` = 1, `src2_data` = I-imm.
  - store → `s_op_store`: `src2_reg` = rs2, `src2_valid` = 0, `src2_data` = S-imm (offset).
  - branch → `s_op_br`: rs1/rs2 as for op, `src2_data` = B-imm.
  - lui/auipc → `s_op_lui`/`s_op_auipc`: `src1_reg` = 0, `src1_valid` = 1, `src2_valid` = 1, `src2_data` = `{instr[31:12], 12'b0}`.
  - jal → `s_op_jal`: `src1_valid` = 1, `src2_data` = J-imm, `pc = og_pc + J-imm`.
  - jalr → `s_op_jalr`: `src1_reg` = rs1, `src2_data` = I-imm, predicted `pc = og_pc + 4`. The back end flushes on a mispredict.
  - All other opcodes are illegal.
- Arithmetic: all immediates are sign-extended to 32 bits; PC sums wrap modulo 2^32.
- rvfi record:
  - `valid = 1`, `inst = instr`, `pc_rdata = og_pc`, `pc_wdata = control_word.pc`.
  - `rs1_addr`/`rs2_addr` are the decoded registers, or 0 where unused.
  - All other fields are 0.

## Timing
- Reset (asynchronous):
  - state = FETCH, `pc = RESET_PC`.
  - `ld_iq = 0`, `control_word.opcode = s_op_invalid` with all other fields 0, `rvfi` = 0.
  - `imem_read` reads 1 as soon as reset deasserts.
- Throughput: one instruction per (memory latency + 1) cycles, plus any queue-stall cycles.
- `ack_i` in cycle N: FETCH in N+1 with the new `imem_address` visible in N+1.
- `ack_i` without `ld_iq` is ignored.
- `flush_ip` and `ack_i` in the same cycle: flush wins and no transfer occurs.
- Reset mid-DRAIN: the outstanding response is not tracked; memory is reset by the same `rst`.

## Test plan
- Reset, then 1-cycle `imem_resp` with `addi x1,x0,5` (0x00500093), `ack_i` held 1:
  - `imem_address` = 0x60.
  - `ld_iq` carries `s_op_imm`, `src2_data` = 5, `pc` = 0x64.
  - The next fetch is at 0x64.
- `ack_i` held 0 for 4 cycles while in ISSUE → `control_word` and `rvfi` are unchanged and `imem_read` = 0; the transfer occurs on the first `ack_i`.
- `jal x0,-8` at 0x80 → `control_word.pc` = 0x78 and the next `imem_address` = 0x78.
- `flush_ip` with `redirect_pc` = 0x200 in FETCH, 2 cycles before `imem_resp` → DRAIN, `imem_address` stays at the old pc, the response is discarded, the next fetch is at 0x200, and no `ld_iq` is produced for the discarded word.
- `flush_ip` and `ack_i` in the same ISSUE cycle → `ld_iq` = 0, nothing is enqueued, and the next fetch is at `redirect_pc`.
- Illegal word 0x0000007F → no `ld_iq`, and the next fetch is at pc+4.
